// File: rtl/mips_encoder.sv
// Encodes add/lw/sw/beq/j requests into 32-bit MIPS words, tags each with a
// running program counter, and queues {word, address} pairs in a small FIFO.
module mips_encoder #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 op,
  input  logic [4:0]                 rs,
  input  logic [4:0]                 rt,
  input  logic [4:0]                 rd,
  input  logic [15:0]                imm,
  input  logic [25:0]                target,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                instr,
  output logic [31:0]                addr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err,
  output logic                       err_sticky
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_LW  = 3'b001;
  localparam logic [2:0] OP_SW  = 3'b010;
  localparam logic [2:0] OP_BEQ = 3'b011;
  localparam logic [2:0] OP_J   = 3'b100;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;

  logic [31:0]   word_mem [DEPTH];
  logic [31:0]   addr_mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic [31:0]   pc;
  logic          err_q;
  logic          sticky_q;

  logic [31:0]   word;
  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready depends only on occupancy, never on out_ready, so a full FIFO
  // refuses input even when it is being drained in the same cycle.
  assign in_ready   = (cnt != FULL);
  assign out_valid  = (cnt != '0);
  assign count      = cnt;
  assign instr      = word_mem[rptr];
  assign addr       = addr_mem[rptr];
  assign err        = err_q;
  assign err_sticky = sticky_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && legal;
  assign pop    = out_valid && out_ready;

  always_comb begin
    word  = 32'h0000_0000;
    legal = 1'b1;
    case (op)
      OP_ADD:  word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FUNCT_ADD};
      OP_LW:   word = {OPC_LW, rs, rt, imm};
      OP_SW:   word = {OPC_SW, rs, rt, imm};
      OP_BEQ:  word = {OPC_BEQ, rs, rt, imm};
      OP_J:    word = {OPC_J, target};
      default: legal = 1'b0;
    endcase
  end

  // Memory is cleared on reset so the head outputs are defined, not X.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      pc       <= RESET_PC;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        word_mem[i] <= 32'h0000_0000;
        addr_mem[i] <= 32'h0000_0000;
      end
    end else begin
      err_q <= accept && !legal;
      if (accept && !legal) begin
        sticky_q <= 1'b1;
      end
      if (push) begin
        word_mem[wptr] <= word;
        addr_mem[wptr] <= pc;
        wptr           <= wptr + 1'b1;
        pc             <= pc + 32'd4;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_encoder.sv
// Bench for mips_encoder: directed scenarios plus a randomized run, all checked
// against a queue-based model that encodes words from the ISA field layout.
module tb_mips_encoder;

  localparam int DEPTH = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [2:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic        out_ready;

  logic        in_ready, out_valid, err, err_sticky;
  logic [31:0] instr, addr;
  logic [2:0]  count;
  logic        in_ready2, out_valid2, err2, err_sticky2;
  logic [31:0] instr2, addr2;
  logic [2:0]  count2;

  int checks;
  int failures;

  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_err;
  logic        m_sticky;

  mips_encoder #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .addr(addr),
    .count(count), .err(err), .err_sticky(err_sticky)
  );

  mips_encoder #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .op(op),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .out_valid(out_valid2), .out_ready(out_ready), .instr(instr2), .addr(addr2),
    .count(count2), .err(err2), .err_sticky(err_sticky2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(input logic [2:0] o, input logic [4:0] s,
                                           input logic [4:0] t, input logic [4:0] d,
                                           input logic [15:0] i, input logic [25:0] tg);
    logic [31:0] s32, t32, d32, i32, tg32;
    s32 = 32'(s); t32 = 32'(t); d32 = 32'(d); i32 = 32'(i); tg32 = 32'(tg);
    case (o)
      3'd0:    return (s32 << 21) | (t32 << 16) | (d32 << 11) | 32'd32;
      3'd1:    return (32'd35 << 26) | (s32 << 21) | (t32 << 16) | i32;
      3'd2:    return (32'd43 << 26) | (s32 << 21) | (t32 << 16) | i32;
      3'd3:    return (32'd4 << 26) | (s32 << 21) | (t32 << 16) | i32;
      default: return (32'd2 << 26) | tg32;
    endcase
  endfunction

  // Advance one clock, updating the model from the inputs currently driven.
  task automatic tick();
    logic acc;
    if (rst) begin
      exp_q.delete();
      m_pc     = 32'h0000_0000;
      m_err    = 1'b0;
      m_sticky = 1'b0;
    end else begin
      acc   = in_valid && (exp_q.size() < DEPTH);
      m_err = acc && (op > 3'd4);
      if (m_err) m_sticky = 1'b1;
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (acc && op <= 3'd4) begin
        exp_q.push_back({ref_word(op, rs, rt, rd, imm, target), m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive(input logic [2:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg);
    in_valid = 1'b1; op = o; rs = s; rt = t; rd = d; imm = i; target = tg;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, count, in_ready, err, err_sticky} !== {1'b0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_flags got ov=%0b cnt=%0d ir=%0b err=%0b st=%0b want 0 0 1 0 0",
               out_valid, count, in_ready, err, err_sticky);
    end
    checks++;
    if (instr !== 32'h0 || addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_head got instr=%h addr=%h want 0 0", instr, addr);
    end
  endtask

  task automatic test_add();
    do_reset();
    drive(3'd0, 5'd17, 5'd18, 5'd16, 16'h0, 26'h0);
    tick();
    idle();
    checks++;
    if (out_valid !== 1'b1 || instr !== 32'h0232_8020 || addr !== 32'h0) begin
      failures++;
      $display("FAIL add_encode got ov=%0b instr=%h addr=%h want 1 02328020 0", out_valid, instr, addr);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      failures++;
      $display("FAIL add_drain got ov=%0b cnt=%0d want 0 0", out_valid, count);
    end
  endtask

  task automatic test_ops();
    logic [31:0] want [4];
    want[0] = 32'h8E30_0020; want[1] = 32'hAE30_0020;
    want[2] = 32'h1211_00C8; want[3] = 32'h0800_03E8;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(3'd1, 5'd17, 5'd16, 5'd9, 16'd32, 26'h3FF_FFFF);
        1: drive(3'd2, 5'd17, 5'd16, 5'd9, 16'd32, 26'h0);
        2: drive(3'd3, 5'd16, 5'd17, 5'd5, 16'd200, 26'h0);
        default: drive(3'd4, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'd1000);
      endcase
      tick();
      checks++;
      if (out_valid !== 1'b1 || instr !== want[i] || addr !== 32'(i * 4)) begin
        failures++;
        $display("FAIL ops_%0d got ov=%0b instr=%h addr=%h want 1 %h %h",
                 i, out_valid, instr, addr, want[i], 32'(i * 4));
      end
    end
    idle();
    tick();
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      failures++;
      $display("FAIL ops_empty got cnt=%0d want 0", count);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(3'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 16'h0, 26'h0);
      tick();
    end
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_flags got cnt=%0d ir=%0b want 4 0", count, in_ready);
    end
    drive(3'd1, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0);
    tick();
    checks++;
    if (count !== 3'd4 || instr !== exp_q[0][63:32] || addr !== 32'h0) begin
      failures++;
      $display("FAIL full_reject got cnt=%0d instr=%h addr=%h want 4 %h 0",
               count, instr, addr, exp_q[0][63:32]);
    end
    idle();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || count !== 3'd3) begin
      failures++;
      $display("FAIL full_pop got ir=%0b cnt=%0d want 1 3", in_ready, count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({instr, addr} !== exp_q[0] || addr !== 32'(4 + i * 4)) begin
        failures++;
        $display("FAIL full_order_%0d got %h %h want %h", i, instr, addr, exp_q[0]);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    drive(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    tick();
    drive(3'b110, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
    tick();
    checks++;
    if (err !== 1'b1 || err_sticky !== 1'b1 || count !== 3'd1) begin
      failures++;
      $display("FAIL illegal_pulse got err=%0b st=%0b cnt=%0d want 1 1 1", err, err_sticky, count);
    end
    drive(3'd0, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0);
    tick();
    idle();
    checks++;
    if (err !== 1'b0 || err_sticky !== 1'b1 || count !== 3'd2) begin
      failures++;
      $display("FAIL illegal_after got err=%0b st=%0b cnt=%0d want 0 1 2", err, err_sticky, count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (addr !== 32'(i * 4) || {instr, addr} !== exp_q[0]) begin
        failures++;
        $display("FAIL illegal_word_%0d got %h %h want %h", i, instr, addr, exp_q[0]);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_pc_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(3'd3, 5'(i), 5'(i + 1), 5'd0, 16'(i), 26'h0);
      tick();
    end
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid2 !== 1'b1 || addr2 !== WRAP_PC + 32'(i * 4)) begin
        failures++;
        $display("FAIL pc_wrap_%0d got ov=%0b addr=%h want 1 %h", i, out_valid2, addr2, WRAP_PC + 32'(i * 4));
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(3'b111, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    tick();
    drive(3'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
    tick();
    tick();
    rst = 1'b1;
    drive(3'd0, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0);
    tick();
    rst = 1'b0;
    idle();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || err_sticky !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got cnt=%0d ov=%0b st=%0b err=%0b want 0 0 0 0", count, out_valid, err_sticky, err);
    end
    drive(3'd4, 5'd0, 5'd0, 5'd0, 16'h0, 26'd7);
    tick();
    idle();
    checks++;
    if (addr !== 32'h0 || addr2 !== WRAP_PC || instr !== 32'h0800_0007) begin
      failures++;
      $display("FAIL reset_mid_pc got addr=%h addr2=%h instr=%h want 0 %h 08000007", addr, addr2, instr, WRAP_PC);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) != 0)
        drive(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
              16'($urandom), 26'($urandom));
      else
        idle();
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (out_valid !== (exp_q.size() != 0) || count !== 3'(exp_q.size()) ||
          in_ready !== (exp_q.size() != DEPTH) || err !== m_err || err_sticky !== m_sticky ||
          (exp_q.size() != 0 && {instr, addr} !== exp_q[0])) begin
        failures++;
        $display("FAIL random_%0d got ov=%0b cnt=%0d ir=%0b err=%0b st=%0b head=%h_%h want cnt=%0d err=%0b st=%0b head=%h",
                 n, out_valid, count, in_ready, err, err_sticky, instr, addr,
                 exp_q.size(), m_err, m_sticky, (exp_q.size() != 0) ? exp_q[0] : 64'h0);
      end
    end
    rst = 1'b0;
    idle();
    out_ready = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    m_pc = 32'h0; m_err = 1'b0; m_sticky = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'h0; target = 26'h0;
    #2;
    test_reset();
    test_add();
    test_ops();
    test_full();
    test_illegal();
    test_pc_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
